prog_loader: RTL and testbench

//  Byte-stream program loader: write side of the byte-addressable instruction memory.
//  - Receives a framed image (length, payload, checksum) over a valid/ready byte stream.
//  - Writes each payload byte at START_POS + index.
//  - Holds the CPU while loading; releases it on a good checksum.

---
 rtl/prog_loader.sv | 142 ++++++++++++++
 tb/tb_prog_loader.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/prog_loader.sv
// prog_loader: byte-stream program loader, write side of the instruction memory.
// Receives a framed image (4-byte little-endian length, payload, 1-byte XOR checksum)
// over a valid/ready byte stream, writes each payload byte to START_POS + index, and
// holds the CPU until a frame with a matching checksum has been loaded.
//
// Ports:
//   clk       system clock, rising edge
//   rst_n     asynchronous active-low reset
//   rx_data   incoming stream byte
//   rx_valid  rx_data valid
//   rx_ready  loader can accept a byte (LEN/DATA/CSUM only)
//   start     one-cycle pulse, re-arms the loader from DONE or ERR
//   wr_en     memory byte-write strobe (one cycle per accepted payload byte)
//   wr_addr   absolute byte address of the write
//   wr_data   byte to write
//   cpu_hold  1 = CPU held; low only in DONE
//   done      image loaded and checksum matched
//   error     length overflow or checksum mismatch
//   byte_cnt  payload bytes written so far
module prog_loader #(
  parameter logic [31:0] MEM_SIZE  = 32'd4096,
  parameter logic [31:0] START_POS = 32'hbfc00000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [7:0]  rx_data,
  input  logic        rx_valid,
  output logic        rx_ready,
  input  logic        start,
  output logic        wr_en,
  output logic [31:0] wr_addr,
  output logic [7:0]  wr_data,
  output logic        cpu_hold,
  output logic        done,
  output logic        error,
  output logic [31:0] byte_cnt
);

  typedef enum logic [2:0] {
    S_LEN,
    S_DATA,
    S_CSUM,
    S_DONE,
    S_ERR
  } state_t;

  state_t      state_q, state_d;
  logic [31:0] len_q;
  logic [1:0]  hdr_cnt_q;
  logic [31:0] idx_q;
  logic [7:0]  csum_q;

  logic        accept;
  logic [31:0] len_full;
  logic [31:0] idx_next;

  assign accept   = rx_valid && rx_ready;
  // Little-endian assembly: each new byte enters at the top, so after four
  // bytes the first one received sits in bits 7:0.
  assign len_full = {rx_data, len_q[31:8]};
  assign idx_next = idx_q + 32'd1;

  // Status outputs are pure decodes of the state so they follow reset at once.
  assign rx_ready = rst_n && (state_q inside {S_LEN, S_DATA, S_CSUM});
  assign done     = (state_q == S_DONE);
  assign error    = (state_q == S_ERR);
  assign cpu_hold = (state_q != S_DONE);
  assign byte_cnt = idx_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_LEN;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_LEN: begin
        if (accept && hdr_cnt_q == 2'd3) begin
          if (len_full > MEM_SIZE)      state_d = S_ERR;
          else if (len_full == '0)      state_d = S_CSUM;
          else                          state_d = S_DATA;
        end
      end
      S_DATA: begin
        if (accept && idx_next == len_q) state_d = S_CSUM;
      end
      S_CSUM: begin
        if (accept) state_d = (rx_data == csum_q) ? S_DONE : S_ERR;
      end
      S_DONE, S_ERR: begin
        if (start) state_d = S_LEN;
      end
      default: state_d = S_LEN;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      len_q     <= '0;
      hdr_cnt_q <= '0;
      idx_q     <= '0;
      csum_q    <= '0;
      wr_en     <= 1'b0;
      wr_addr   <= '0;
      wr_data   <= '0;
    end else begin
      wr_en <= 1'b0;
      case (state_q)
        S_LEN: begin
          if (accept) begin
            len_q     <= len_full;
            // Wraps back to 0 after the fourth byte, ready for the next frame.
            hdr_cnt_q <= hdr_cnt_q + 2'd1;
          end
        end
        S_DATA: begin
          if (accept) begin
            wr_en   <= 1'b1;
            wr_addr <= START_POS + idx_q;
            wr_data <= rx_data;
            idx_q   <= idx_next;
            csum_q  <= csum_q ^ rx_data;
          end
        end
        S_DONE, S_ERR: begin
          if (start) begin
            len_q     <= '0;
            hdr_cnt_q <= '0;
            idx_q     <= '0;
            csum_q    <= '0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_prog_loader.sv
// Directed bench for prog_loader: framed images driven over the byte stream,
// outputs sampled at the falling edge or 1 ns after the rising edge.
module tb_prog_loader;

  logic        clk;
  logic        rst_n;
  logic [7:0]  rx_data;
  logic        rx_valid;
  logic        rx_ready;
  logic        start;
  logic        wr_en;
  logic [31:0] wr_addr;
  logic [7:0]  wr_data;
  logic        cpu_hold;
  logic        done;
  logic        error;
  logic [31:0] byte_cnt;

  int unsigned vectors;
  int unsigned miscompares;
  int unsigned wcount;
  int unsigned w0;
  logic [7:0]  pay [0:15];
  logic [7:0]  cs;

  prog_loader #(
    .MEM_SIZE (32'd4096),
    .START_POS(32'hbfc00000)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .rx_data  (rx_data),
    .rx_valid (rx_valid),
    .rx_ready (rx_ready),
    .start    (start),
    .wr_en    (wr_en),
    .wr_addr  (wr_addr),
    .wr_data  (wr_data),
    .cpu_hold (cpu_hold),
    .done     (done),
    .error    (error),
    .byte_cnt (byte_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Every cycle with wr_en high is one memory write.
  initial wcount = 0;
  always @(negedge clk) if (wr_en === 1'b1) wcount++;

  initial begin
    #200000;
    $display("FAIL global_timeout: observed still running, expected finished");
    $fatal(1, "bench timeout");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic idle(input int unsigned n);
    rx_valid = 1'b0;
    repeat (n) @(negedge clk);
  endtask

  task automatic pulse_start();
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b, input bit is_payload, input logic [31:0] exp_addr);
    int unsigned n;
    n = 0;
    @(negedge clk);
    rx_data  = b;
    rx_valid = 1'b1;
    while (rx_ready !== 1'b1 && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("rx_ready_wait", 32'(rx_ready), 32'd1);
    @(posedge clk);
    #1;
    if (is_payload) begin
      chk("wr_en_after_accept", 32'(wr_en), 32'd1);
      chk("wr_addr", wr_addr, exp_addr);
      chk("wr_data", 32'(wr_data), 32'(b));
    end else begin
      chk("wr_en_idle", 32'(wr_en), 32'd0);
    end
  endtask

  task automatic send_header(input logic [31:0] len);
    for (int i = 0; i < 4; i++) send_byte(len[8*i +: 8], 1'b0, 32'd0);
  endtask

  task automatic send_frame(input logic [31:0] len, input int unsigned npay,
                            input logic [7:0] csum, input bit gaps);
    send_header(len);
    for (int i = 0; i < int'(npay); i++) begin
      if (gaps) idle($urandom_range(0, 3));
      send_byte(pay[i], 1'b1, 32'hbfc00000 + 32'(i));
    end
    send_byte(csum, 1'b0, 32'd0);
    idle(2);
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    rst_n    = 1'b0;
    rx_valid = 1'b0;
    rx_data  = 8'h00;
    start    = 1'b0;

    // Reset state
    #3;
    chk("rst_rx_ready", 32'(rx_ready), 32'd0);
    chk("rst_wr_en", 32'(wr_en), 32'd0);
    chk("rst_wr_addr", wr_addr, 32'd0);
    chk("rst_wr_data", 32'(wr_data), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_error", 32'(error), 32'd0);
    chk("rst_byte_cnt", byte_cnt, 32'd0);
    chk("rst_cpu_hold", 32'(cpu_hold), 32'd1);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("post_rst_rx_ready", 32'(rx_ready), 32'd1);

    // Good 4-byte frame
    pay[0] = 8'h13; pay[1] = 8'h00; pay[2] = 8'h00; pay[3] = 8'h00;
    w0 = wcount;
    send_frame(32'd4, 4, 8'h13, 1'b0);
    chk("a_writes", wcount - w0, 32'd4);
    chk("a_done", 32'(done), 32'd1);
    chk("a_error", 32'(error), 32'd0);
    chk("a_cpu_hold", 32'(cpu_hold), 32'd0);
    chk("a_byte_cnt", byte_cnt, 32'd4);
    chk("a_rx_ready", 32'(rx_ready), 32'd0);

    // Re-arm, then same frame with a bad checksum
    pulse_start();
    chk("start_done", 32'(done), 32'd0);
    chk("start_cpu_hold", 32'(cpu_hold), 32'd1);
    chk("start_byte_cnt", byte_cnt, 32'd0);
    chk("start_rx_ready", 32'(rx_ready), 32'd1);
    w0 = wcount;
    send_frame(32'd4, 4, 8'h12, 1'b0);
    chk("b_writes", wcount - w0, 32'd4);
    chk("b_error", 32'(error), 32'd1);
    chk("b_done", 32'(done), 32'd0);
    chk("b_cpu_hold", 32'(cpu_hold), 32'd1);
    chk("b_rx_ready", 32'(rx_ready), 32'd0);

    // Length overflow: 4097 > MEM_SIZE
    pulse_start();
    chk("start_err_error", 32'(error), 32'd0);
    w0 = wcount;
    send_header(32'd4097);
    chk("ovf_error", 32'(error), 32'd1);
    chk("ovf_rx_ready", 32'(rx_ready), 32'd0);
    idle(4);
    chk("ovf_writes", wcount - w0, 32'd0);
    chk("ovf_done", 32'(done), 32'd0);

    // Boundary: len == MEM_SIZE is accepted (goes to DATA, not ERR)
    pulse_start();
    send_header(32'd4096);
    chk("max_len_error", 32'(error), 32'd0);
    chk("max_len_rx_ready", 32'(rx_ready), 32'd1);
    idle(1);
    rst_n = 1'b0;
    #2;
    rst_n = 1'b1;

    // Empty image
    w0 = wcount;
    send_frame(32'd0, 0, 8'h00, 1'b0);
    chk("z_writes", wcount - w0, 32'd0);
    chk("z_done", 32'(done), 32'd1);
    chk("z_byte_cnt", byte_cnt, 32'd0);

    // Second image after DONE
    pulse_start();
    pay[0] = 8'hAA; pay[1] = 8'h55;
    w0 = wcount;
    send_frame(32'd2, 2, 8'hFF, 1'b0);
    chk("c_writes", wcount - w0, 32'd2);
    chk("c_done", 32'(done), 32'd1);
    chk("c_byte_cnt", byte_cnt, 32'd2);

    // Random gaps, plus a start pulse mid-load that must be ignored
    pulse_start();
    cs = 8'h00;
    for (int i = 0; i < 8; i++) begin
      pay[i] = 8'($urandom_range(0, 255));
      cs = cs ^ pay[i];
    end
    w0 = wcount;
    send_header(32'd8);
    for (int i = 0; i < 8; i++) begin
      idle($urandom_range(0, 3));
      if (i == 3) pulse_start();
      send_byte(pay[i], 1'b1, 32'hbfc00000 + 32'(i));
    end
    send_byte(cs, 1'b0, 32'd0);
    idle(2);
    chk("r_writes", wcount - w0, 32'd8);
    chk("r_done", 32'(done), 32'd1);
    chk("r_byte_cnt", byte_cnt, 32'd8);

    // Reset mid-payload after 2 of 8 bytes
    pulse_start();
    send_header(32'd8);
    send_byte(8'h11, 1'b1, 32'hbfc00000);
    send_byte(8'h22, 1'b1, 32'hbfc00001);
    rx_valid = 1'b0;
    #1;
    rst_n = 1'b0;
    #1;
    chk("mid_rst_wr_en", 32'(wr_en), 32'd0);
    chk("mid_rst_byte_cnt", byte_cnt, 32'd0);
    chk("mid_rst_cpu_hold", 32'(cpu_hold), 32'd1);
    chk("mid_rst_rx_ready", 32'(rx_ready), 32'd0);
    chk("mid_rst_wr_addr", wr_addr, 32'd0);
    w0 = wcount;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    chk("mid_rst_no_writes", wcount - w0, 32'd0);
    pay[0] = 8'hAA; pay[1] = 8'h55;
    w0 = wcount;
    send_frame(32'd2, 2, 8'hFF, 1'b0);
    chk("d_writes", wcount - w0, 32'd2);
    chk("d_done", 32'(done), 32'd1);
    chk("d_byte_cnt", byte_cnt, 32'd2);
    chk("d_error", 32'(error), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
